// File: rtl/ccip_inflight_tracker.sv
`default_nettype none
// =============================================================================
// ccip_inflight_tracker : passive CCI-P monitor of outstanding read/write requests
// Optional duplicate-tag check: define CCIP_TRACKER_DUPCHK_EN.   Rev 1.0
// =============================================================================
module ccip_inflight_tracker #(
   parameter int RD_DEPTH       = 16,
   parameter int WR_DEPTH       = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int MDATA_W        = 16
) (
   input  logic                          clk,
   input  logic                          SoftReset_n,
   input  logic                          c0tx_valid,
   input  logic [MDATA_W-1:0]            c0tx_mdata,
   input  logic [1:0]                    c0tx_len,
   input  logic                          c1tx_valid,
   input  logic                          c1tx_sop,
   input  logic [MDATA_W-1:0]            c1tx_mdata,
   input  logic [1:0]                    c1tx_len,
   input  logic                          c0rx_rd_valid,
   input  logic [MDATA_W-1:0]            c0rx_mdata,
   input  logic                          c1rx_wr_valid,
   input  logic [MDATA_W-1:0]            c1rx_mdata,
   input  logic                          c1rx_format,
   output logic [$clog2(RD_DEPTH):0]     rd_inflight,
   output logic [$clog2(WR_DEPTH):0]     wr_inflight,
   output logic                          err_orphan_rd,
   output logic                          err_orphan_wr,
   output logic                          err_table_full,
   output logic                          err_illegal_len,
   output logic                          err_timeout,
   output logic                          err_dup_mdata,
   output logic [MDATA_W-1:0]            err_mdata
);

   localparam int RD_IDX_W = $clog2(RD_DEPTH);
   localparam int WR_IDX_W = $clog2(WR_DEPTH);
   localparam int RD_CNT_W = $clog2(RD_DEPTH) + 1;
   localparam int WR_CNT_W = $clog2(WR_DEPTH) + 1;
   localparam int AGE_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);
   localparam logic [AGE_W-1:0] AGE_EXP = AGE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       LEN_ILLEGAL = 2'd2;

   logic [RD_DEPTH-1:0] rd_valid_q, rd_valid_d;
   logic [MDATA_W-1:0]  rd_mdata_q [RD_DEPTH];
   logic [MDATA_W-1:0]  rd_mdata_d [RD_DEPTH];
   logic [2:0]          rd_rem_q   [RD_DEPTH];
   logic [2:0]          rd_rem_d   [RD_DEPTH];
   logic [AGE_W-1:0]    rd_age_q   [RD_DEPTH];
   logic [AGE_W-1:0]    rd_age_d   [RD_DEPTH];

   logic [WR_DEPTH-1:0] wr_valid_q, wr_valid_d;
   logic [MDATA_W-1:0]  wr_mdata_q [WR_DEPTH];
   logic [MDATA_W-1:0]  wr_mdata_d [WR_DEPTH];
   logic [2:0]          wr_rem_q   [WR_DEPTH];
   logic [2:0]          wr_rem_d   [WR_DEPTH];
   logic [AGE_W-1:0]    wr_age_q   [WR_DEPTH];
   logic [AGE_W-1:0]    wr_age_d   [WR_DEPTH];

   logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic                orphan_rd_q, orphan_rd_d;
   logic                orphan_wr_q, orphan_wr_d;
   logic                full_q, full_d;
   logic                ill_q, ill_d;
   logic                timeout_q, timeout_d;
   logic [MDATA_W-1:0]  err_mdata_q, err_mdata_d;

   logic                rd_free_found, rd_hit_found, rd_exp_found;
   logic [RD_IDX_W-1:0] rd_free_idx, rd_hit_idx, rd_exp_idx;
   logic                wr_free_found, wr_hit_found, wr_exp_found;
   logic [WR_IDX_W-1:0] wr_free_idx, wr_hit_idx, wr_exp_idx;
   logic                rd_req, wr_req, wr_start, rd_ill, wr_ill, rd_full, wr_full;
   logic                dup_hit;
   logic [MDATA_W-1:0]  dup_tag;

   always_comb begin
      rd_valid_d    = rd_valid_q;
      rd_mdata_d    = rd_mdata_q;
      rd_rem_d      = rd_rem_q;
      rd_age_d      = rd_age_q;
      wr_valid_d    = wr_valid_q;
      wr_mdata_d    = wr_mdata_q;
      wr_rem_d      = wr_rem_q;
      wr_age_d      = wr_age_q;
      rd_free_found = 1'b0;
      rd_hit_found  = 1'b0;
      rd_exp_found  = 1'b0;
      rd_free_idx   = '0;
      rd_hit_idx    = '0;
      rd_exp_idx    = '0;
      wr_free_found = 1'b0;
      wr_hit_found  = 1'b0;
      wr_exp_found  = 1'b0;
      wr_free_idx   = '0;
      wr_hit_idx    = '0;
      wr_exp_idx    = '0;
      rd_cnt_d      = '0;
      wr_cnt_d      = '0;

      // All searches look at the pre-edge table; lowest index wins
      for (int i = 0; i < RD_DEPTH; i++) begin
         if (!rd_valid_q[i] && !rd_free_found) begin
            rd_free_found = 1'b1;
            rd_free_idx   = RD_IDX_W'(i);
         end
         if (rd_valid_q[i] && rd_mdata_q[i] == c0rx_mdata && !rd_hit_found) begin
            rd_hit_found = 1'b1;
            rd_hit_idx   = RD_IDX_W'(i);
         end
         if (rd_valid_q[i] && rd_age_q[i] >= AGE_EXP && !rd_exp_found) begin
            rd_exp_found = 1'b1;
            rd_exp_idx   = RD_IDX_W'(i);
         end
         if (rd_valid_q[i] && rd_age_q[i] != AGE_MAX)
            rd_age_d[i] = rd_age_q[i] + 1'b1;
      end
      for (int i = 0; i < WR_DEPTH; i++) begin
         if (!wr_valid_q[i] && !wr_free_found) begin
            wr_free_found = 1'b1;
            wr_free_idx   = WR_IDX_W'(i);
         end
         if (wr_valid_q[i] && wr_mdata_q[i] == c1rx_mdata && !wr_hit_found) begin
            wr_hit_found = 1'b1;
            wr_hit_idx   = WR_IDX_W'(i);
         end
         if (wr_valid_q[i] && wr_age_q[i] >= AGE_EXP && !wr_exp_found) begin
            wr_exp_found = 1'b1;
            wr_exp_idx   = WR_IDX_W'(i);
         end
         if (wr_valid_q[i] && wr_age_q[i] != AGE_MAX)
            wr_age_d[i] = wr_age_q[i] + 1'b1;
      end

      rd_ill   = c0tx_valid && (c0tx_len == LEN_ILLEGAL);
      wr_ill   = c1tx_valid && (c1tx_len == LEN_ILLEGAL);
      rd_req   = c0tx_valid && !rd_ill;
      wr_start = c1tx_valid && (c1tx_sop || c1tx_len == 2'd0);
      wr_req   = wr_start && !wr_ill;
      rd_full  = rd_req && !rd_free_found;
      wr_full  = wr_req && !wr_free_found;

      ill_d       = rd_ill || wr_ill;
      full_d      = rd_full || wr_full;
      orphan_rd_d = c0rx_rd_valid && !rd_hit_found;
      orphan_wr_d = c1rx_wr_valid && !wr_hit_found;
      timeout_d   = rd_exp_found || wr_exp_found;

      if (c0rx_rd_valid && rd_hit_found) begin
         rd_rem_d[rd_hit_idx] = rd_rem_q[rd_hit_idx] - 3'd1;
         if (rd_rem_q[rd_hit_idx] <= 3'd1)
            rd_valid_d[rd_hit_idx] = 1'b0;
      end
      if (c1rx_wr_valid && wr_hit_found) begin
         wr_rem_d[wr_hit_idx] = wr_rem_q[wr_hit_idx] - 3'd1;
         if (c1rx_format || wr_rem_q[wr_hit_idx] <= 3'd1)
            wr_valid_d[wr_hit_idx] = 1'b0;
      end

      // One expiry per cycle; saturated ages keep the others pending
      if (rd_exp_found)
         rd_valid_d[rd_exp_idx] = 1'b0;
      else if (wr_exp_found)
         wr_valid_d[wr_exp_idx] = 1'b0;

      if (rd_req && rd_free_found) begin
         rd_valid_d[rd_free_idx] = 1'b1;
         rd_mdata_d[rd_free_idx] = c0tx_mdata;
         rd_rem_d[rd_free_idx]   = {1'b0, c0tx_len} + 3'd1;
         rd_age_d[rd_free_idx]   = '0;
      end
      if (wr_req && wr_free_found) begin
         wr_valid_d[wr_free_idx] = 1'b1;
         wr_mdata_d[wr_free_idx] = c1tx_mdata;
         wr_rem_d[wr_free_idx]   = {1'b0, c1tx_len} + 3'd1;
         wr_age_d[wr_free_idx]   = '0;
      end

      err_mdata_d = err_mdata_q;
      if (ill_d)
         err_mdata_d = rd_ill ? c0tx_mdata : c1tx_mdata;
      else if (full_d)
         err_mdata_d = rd_full ? c0tx_mdata : c1tx_mdata;
      else if (orphan_rd_d)
         err_mdata_d = c0rx_mdata;
      else if (orphan_wr_d)
         err_mdata_d = c1rx_mdata;
      else if (timeout_d)
         err_mdata_d = rd_exp_found ? rd_mdata_q[rd_exp_idx] : wr_mdata_q[wr_exp_idx];
      else if (dup_hit)
         err_mdata_d = dup_tag;

      for (int i = 0; i < RD_DEPTH; i++)
         rd_cnt_d = rd_cnt_d + RD_CNT_W'(rd_valid_d[i]);
      for (int i = 0; i < WR_DEPTH; i++)
         wr_cnt_d = wr_cnt_d + WR_CNT_W'(wr_valid_d[i]);
   end

`ifdef CCIP_TRACKER_DUPCHK_EN
   logic dup_q, rd_dup, wr_dup;

   always_comb begin
      rd_dup = 1'b0;
      wr_dup = 1'b0;
      for (int i = 0; i < RD_DEPTH; i++)
         if (rd_valid_q[i] && rd_mdata_q[i] == c0tx_mdata) rd_dup = 1'b1;
      for (int i = 0; i < WR_DEPTH; i++)
         if (wr_valid_q[i] && wr_mdata_q[i] == c1tx_mdata) wr_dup = 1'b1;
      dup_hit = (rd_req && rd_free_found && rd_dup) || (wr_req && wr_free_found && wr_dup);
      dup_tag = (rd_req && rd_free_found && rd_dup) ? c0tx_mdata : c1tx_mdata;
   end

   always_ff @(posedge clk) begin
      if (!SoftReset_n) dup_q <= 1'b0;
      else              dup_q <= dup_hit;
   end

   assign err_dup_mdata = dup_q;
`else
   assign dup_hit       = 1'b0;
   assign dup_tag       = '0;
   assign err_dup_mdata = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!SoftReset_n) begin
         rd_valid_q  <= '0;
         rd_mdata_q  <= '{default: '0};
         rd_rem_q    <= '{default: '0};
         rd_age_q    <= '{default: '0};
         wr_valid_q  <= '0;
         wr_mdata_q  <= '{default: '0};
         wr_rem_q    <= '{default: '0};
         wr_age_q    <= '{default: '0};
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         orphan_rd_q <= 1'b0;
         orphan_wr_q <= 1'b0;
         full_q      <= 1'b0;
         ill_q       <= 1'b0;
         timeout_q   <= 1'b0;
         err_mdata_q <= '0;
      end else begin
         rd_valid_q  <= rd_valid_d;
         rd_mdata_q  <= rd_mdata_d;
         rd_rem_q    <= rd_rem_d;
         rd_age_q    <= rd_age_d;
         wr_valid_q  <= wr_valid_d;
         wr_mdata_q  <= wr_mdata_d;
         wr_rem_q    <= wr_rem_d;
         wr_age_q    <= wr_age_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         orphan_rd_q <= orphan_rd_d;
         orphan_wr_q <= orphan_wr_d;
         full_q      <= full_d;
         ill_q       <= ill_d;
         timeout_q   <= timeout_d;
         err_mdata_q <= err_mdata_d;
      end
   end

   assign rd_inflight     = rd_cnt_q;
   assign wr_inflight     = wr_cnt_q;
   assign err_orphan_rd   = orphan_rd_q;
   assign err_orphan_wr   = orphan_wr_q;
   assign err_table_full  = full_q;
   assign err_illegal_len = ill_q;
   assign err_timeout     = timeout_q;
   assign err_mdata       = err_mdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ccip_inflight_tracker.sv
`default_nettype none
// =============================================================================
// tb_ccip_inflight_tracker : scoreboard bench, RD_DEPTH=2 WR_DEPTH=4 TIMEOUT=8
// =============================================================================
module tb_ccip_inflight_tracker;

   localparam logic [5:0] E_ORD  = 6'b100000;
   localparam logic [5:0] E_OWR  = 6'b010000;
   localparam logic [5:0] E_FULL = 6'b001000;
   localparam logic [5:0] E_ILL  = 6'b000100;
   localparam logic [5:0] E_TO   = 6'b000010;
   localparam logic [5:0] E_DUP  = 6'b000001;

   typedef struct {
      logic [1:0]  rd;
      logic [2:0]  wr;
      logic [5:0]  err;
      logic [15:0] md;
   } exp_t;

   logic        clk = 1'b0;
   logic        SoftReset_n;
   logic        c0tx_valid, c1tx_valid, c1tx_sop, c0rx_rd_valid, c1rx_wr_valid, c1rx_format;
   logic [15:0] c0tx_mdata, c1tx_mdata, c0rx_mdata, c1rx_mdata;
   logic [1:0]  c0tx_len, c1tx_len;
   logic [1:0]  rd_inflight;
   logic [2:0]  wr_inflight;
   logic        err_orphan_rd, err_orphan_wr, err_table_full, err_illegal_len;
   logic        err_timeout, err_dup_mdata;
   logic [15:0] err_mdata;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   ccip_inflight_tracker #(
      .RD_DEPTH(2), .WR_DEPTH(4), .TIMEOUT_CYCLES(8), .MDATA_W(16)
   ) dut (
      .clk(clk), .SoftReset_n(SoftReset_n),
      .c0tx_valid(c0tx_valid), .c0tx_mdata(c0tx_mdata), .c0tx_len(c0tx_len),
      .c1tx_valid(c1tx_valid), .c1tx_sop(c1tx_sop), .c1tx_mdata(c1tx_mdata), .c1tx_len(c1tx_len),
      .c0rx_rd_valid(c0rx_rd_valid), .c0rx_mdata(c0rx_mdata),
      .c1rx_wr_valid(c1rx_wr_valid), .c1rx_mdata(c1rx_mdata), .c1rx_format(c1rx_format),
      .rd_inflight(rd_inflight), .wr_inflight(wr_inflight),
      .err_orphan_rd(err_orphan_rd), .err_orphan_wr(err_orphan_wr),
      .err_table_full(err_table_full), .err_illegal_len(err_illegal_len),
      .err_timeout(err_timeout), .err_dup_mdata(err_dup_mdata), .err_mdata(err_mdata)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      c0tx_valid = 1'b0; c1tx_valid = 1'b0; c1tx_sop = 1'b0;
      c0rx_rd_valid = 1'b0; c1rx_wr_valid = 1'b0; c1rx_format = 1'b0;
      c0tx_mdata = '0; c1tx_mdata = '0; c0rx_mdata = '0; c1rx_mdata = '0;
      c0tx_len = 2'd0; c1tx_len = 2'd0;
   endtask

   // Push the expectation for the inputs currently driven, clock once, then compare
   task automatic tick(input logic [1:0] rd, input logic [2:0] wr,
                       input logic [5:0] err, input logic [15:0] md);
      exp_t e;
      exp_t got;
      e.rd = rd; e.wr = wr; e.err = err; e.md = md;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check_val("rd_inflight", 32'(rd_inflight), 32'(got.rd));
      check_val("wr_inflight", 32'(wr_inflight), 32'(got.wr));
      check_val("err_flags", 32'({err_orphan_rd, err_orphan_wr, err_table_full,
                                  err_illegal_len, err_timeout, err_dup_mdata}), 32'(got.err));
      check_val("err_mdata", 32'(err_mdata), 32'(got.md));
      idle_inputs();
   endtask

   task automatic rd_req(input logic [15:0] tag, input logic [1:0] len);
      c0tx_valid = 1'b1; c0tx_mdata = tag; c0tx_len = len;
   endtask

   task automatic wr_req(input logic [15:0] tag, input logic sop, input logic [1:0] len);
      c1tx_valid = 1'b1; c1tx_mdata = tag; c1tx_sop = sop; c1tx_len = len;
   endtask

   task automatic rd_rsp(input logic [15:0] tag);
      c0rx_rd_valid = 1'b1; c0rx_mdata = tag;
   endtask

   task automatic wr_rsp(input logic [15:0] tag, input logic fmt);
      c1rx_wr_valid = 1'b1; c1rx_mdata = tag; c1rx_format = fmt;
   endtask

   task automatic do_reset();
      SoftReset_n = 1'b0;
      tick(2'd0, 3'd0, 6'd0, 16'h0000);
      SoftReset_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      SoftReset_n = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // 2CL read retired by two response beats
      rd_req(16'h0012, 2'd1);  tick(2'd1, 3'd0, 6'd0, 16'h0000);
      rd_rsp(16'h0012);        tick(2'd1, 3'd0, 6'd0, 16'h0000);
      rd_rsp(16'h0012);        tick(2'd0, 3'd0, 6'd0, 16'h0000);

      // 4CL write closed by one packed response; 2CL write by two beats
      wr_req(16'h00A0, 1'b1, 2'd3); tick(2'd0, 3'd1, 6'd0, 16'h0000);
      wr_rsp(16'h00A0, 1'b1);       tick(2'd0, 3'd0, 6'd0, 16'h0000);
      wr_req(16'h00C0, 1'b1, 2'd1); tick(2'd0, 3'd1, 6'd0, 16'h0000);
      wr_rsp(16'h00C0, 1'b0);       tick(2'd0, 3'd1, 6'd0, 16'h0000);
      wr_rsp(16'h00C0, 1'b0);       tick(2'd0, 3'd0, 6'd0, 16'h0000);

      // Illegal length pulses once; err_mdata holds afterwards
      rd_req(16'h0033, 2'd2);  tick(2'd0, 3'd0, E_ILL, 16'h0033);
      tick(2'd0, 3'd0, 6'd0, 16'h0033);

      // Table full; a slot freed this cycle is not reusable yet
      rd_req(16'h0001, 2'd0);  tick(2'd1, 3'd0, 6'd0, 16'h0033);
      rd_req(16'h0002, 2'd0);  tick(2'd2, 3'd0, 6'd0, 16'h0033);
      rd_req(16'h0003, 2'd0);  tick(2'd2, 3'd0, E_FULL, 16'h0003);
      rd_req(16'h0004, 2'd0);
      rd_rsp(16'h0002);        tick(2'd1, 3'd0, E_FULL, 16'h0004);
      do_reset();

      // Same-tag allocate: duplicate flagged only when the check is built in
      rd_req(16'h0007, 2'd0);  tick(2'd1, 3'd0, 6'd0, 16'h0000);
      rd_req(16'h0007, 2'd0);
`ifdef CCIP_TRACKER_DUPCHK_EN
      tick(2'd2, 3'd0, E_DUP, 16'h0007);
`else
      tick(2'd2, 3'd0, 6'd0, 16'h0000);
`endif
      do_reset();

      // Timeout after 8 cycles, then the late response is an orphan
      rd_req(16'h0055, 2'd0);  tick(2'd1, 3'd0, 6'd0, 16'h0000);
      for (int i = 0; i < 7; i++) tick(2'd1, 3'd0, 6'd0, 16'h0000);
      tick(2'd0, 3'd0, E_TO, 16'h0055);
      tick(2'd0, 3'd0, 6'd0, 16'h0055);
      rd_rsp(16'h0055);        tick(2'd0, 3'd0, E_ORD, 16'h0055);

      wr_rsp(16'h0077, 1'b0);  tick(2'd0, 3'd0, E_OWR, 16'h0077);

      // A response never matches a request issued in the same cycle
      rd_req(16'h0009, 2'd0);
      rd_rsp(16'h0009);        tick(2'd1, 3'd0, E_ORD, 16'h0009);
      rd_rsp(16'h0009);        tick(2'd0, 3'd0, 6'd0, 16'h0009);

      // err_mdata priority: illegal length over orphan write
      rd_req(16'h0044, 2'd2);
      wr_rsp(16'h0066, 1'b0);  tick(2'd0, 3'd0, E_ILL | E_OWR, 16'h0044);

      // Non-sop multi-CL beat is ignored; single-CL beat without sop allocates
      wr_req(16'h0088, 1'b0, 2'd1); tick(2'd0, 3'd0, 6'd0, 16'h0044);
      wr_req(16'h0089, 1'b0, 2'd0); tick(2'd0, 3'd1, 6'd0, 16'h0044);
      wr_rsp(16'h0089, 1'b0);       tick(2'd0, 3'd0, 6'd0, 16'h0044);

      // Simultaneous expiry: read reported first, write on the next cycle
      do_reset();
      rd_req(16'h00A1, 2'd0);
      wr_req(16'h00B1, 1'b1, 2'd0); tick(2'd1, 3'd1, 6'd0, 16'h0000);
      for (int i = 0; i < 7; i++) tick(2'd1, 3'd1, 6'd0, 16'h0000);
      tick(2'd0, 3'd1, E_TO, 16'h00A1);
      tick(2'd0, 3'd0, E_TO, 16'h00B1);
      tick(2'd0, 3'd0, 6'd0, 16'h00B1);

      // Reset mid-stream clears everything on the next edge
      rd_req(16'h0101, 2'd3);
      wr_req(16'h0202, 1'b1, 2'd3); tick(2'd1, 3'd1, 6'd0, 16'h00B1);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
